// File: rtl/uart_rx_if.sv
// APB responder bus bundle for the UART receiver.
interface uart_rx_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/uart_rx.sv
// APB UART receiver: 8N1 deserialiser feeding an RX FIFO, with status/ctrl/div registers and a level irq.
module uart_rx #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 868
) (
  input  logic     clk,
  input  logic     rts,
  uart_rx_if.slave apb,
  input  logic     rx,
  output logic     irq
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bidx_q, bidx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        rx_meta_q, rx_s_q;
  logic        en_q, irqen_q, ovr_q, fe_q, irq_q;
  logic [15:0] div_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, count;
  logic        empty, full, push_req, fe_set, push, pop, ovr_set;
  logic        access, wr_err, wr_ok;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;
  logic        unused_bits;

  always_ff @(posedge clk) begin
    if (!rts) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign access  = apb.psel & apb.penable;
  assign reg_sel = apb.paddr[3:2];
  assign wr_err  = apb.pwrite & ((reg_sel == 2'd0) | (apb.pstb != 4'hF));
  assign wr_ok   = access & apb.pwrite & ~wr_err;
  assign apb.pready = access;
  assign apb.perr   = access & wr_err;
  assign unused_bits = ^{apb.paddr[ADDR_WIDTH-1:4], apb.paddr[1:0], apb.pdata[DATA_WIDTH-1:16]};

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(FIFO_DEPTH));
  assign pop   = access & ~apb.pwrite & (reg_sel == 2'd0) & ~empty;
  // Pop is applied before push, so a full FIFO still accepts a byte when read in the same cycle.
  assign push    = push_req & (~full | pop);
  assign ovr_set = push_req & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (!rts) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = empty ? 32'h8000_0000 : {24'b0, mem_q[rptr_q[AW-1:0]]};
      2'd1: rdata = {19'b0, 5'(count), 4'b0, fe_q, ovr_q, full, ~empty};
      2'd2: rdata = {30'b0, irqen_q, en_q};
      default: rdata = {16'b0, div_q};
    endcase
  end

  assign apb.prdata = (access & ~apb.pwrite) ? DATA_WIDTH'(rdata) : '0;

  // Sticky error bits: a hardware set in the same cycle as a clear-write wins.
  always_ff @(posedge clk) begin
    if (!rts) begin
      en_q    <= 1'b0;
      irqen_q <= 1'b0;
      div_q   <= 16'(DEFAULT_DIV);
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_ok && reg_sel == 2'd2) begin
        en_q    <= apb.pdata[0];
        irqen_q <= apb.pdata[1];
      end
      if (wr_ok && reg_sel == 2'd3)
        div_q <= (apb.pdata[15:0] < 16'd4) ? 16'd4 : apb.pdata[15:0];
      ovr_q <= ovr_set | (ovr_q & ~(wr_ok & (reg_sel == 2'd1) & apb.pdata[2]));
      fe_q  <= fe_set  | (fe_q  & ~(wr_ok & (reg_sel == 2'd1) & apb.pdata[3]));
      irq_q <= irqen_q & (~empty | ovr_q | fe_q);
    end
  end

  assign irq = irq_q;

  always_ff @(posedge clk) begin
    if (!rts) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bidx_d   = bidx_q;
    shreg_d  = shreg_q;
    push_req = 1'b0;
    fe_set   = 1'b0;
    if (!en_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            cnt_d   = div_q >> 1;
            state_d = S_START;
          end
        end
        S_START: begin
          if (cnt_q == '0) begin
            if (!rx_s_q) begin
              cnt_d   = div_q - 16'd1;
              bidx_d  = '0;
              state_d = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (cnt_q == '0) begin
            shreg_d = {rx_s_q, shreg_q[7:1]};
            cnt_d   = div_q - 16'd1;
            if (bidx_q == 3'd7) state_d = S_STOP;
            else                bidx_d  = bidx_q + 3'd1;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        S_STOP: begin
          if (cnt_q == '0) begin
            if (rx_s_q) push_req = 1'b1;
            else        fe_set   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- APB responder UART receiver; the receive-direction counterpart of the transmit-only console peripheral.
- Deserialises 8N1 frames from a serial input pin into an RX FIFO.
- The CPU reads bytes and status over the APB bus.
- Raises a level interrupt to the interrupt controller when data is waiting or an error is latched.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
FIFO_DEPTH, 16, RX FIFO entries (power of two, >=2)
DEFAULT_DIV, 868, reset value of DIV (clocks per bit)

Ports:
clk  in  1  system clock, all logic rising-edge
rts  in  1  reset, synchronous, active-low
paddr  in  ADDR_WIDTH  APB address; only paddr[3:2] decoded, paddr[1:0] ignored
pdata  in  DATA_WIDTH  APB write data
prdata  out  DATA_WIDTH  APB read data
psel  in  1  APB select
penable  in  1  APB access phase
pwrite  in  1  1=write
pstb  in  4  byte strobes
pready  out  1  transfer complete
perr  out  1  transfer error (valid with pready)
rx  in  1  serial input, idle high, asynchronous
irq  out  1  level interrupt

Behaviour:
- Reset (rts=0 at clk edge): prdata=0, pready=0, perr=0, irq=0, FIFO empty, FSM IDLE, CTRL=0, DIV=DEFAULT_DIV, sticky errors cleared. Reset mid-frame discards the partial byte.
- rx passes through a 2-flop synchroniser, initialised to 1; all FSM decisions use the synchronised value.
- APB timing: zero wait state.
  - pready = psel & penable, driven combinationally.
  - prdata is valid in the access cycle and 0 otherwise.
  - Register side effects happen on the access-cycle edge (psel & penable).
- Register map (offsets):
  - 0x0 DATA, read-only. Returns {empty,23'b0,byte}. If the FIFO is non-empty it returns the head byte and pops it. If empty it returns 0x80000000 and nothing changes.
  - 0x4 STATUS:
    - Bit0 not_empty, bit1 full, bit2 overrun (sticky), bit3 framing_err (sticky), bits[12:8] count.
    - Write 1 to bit2/bit3 clears the bit; other bits are read-only.
  - 0x8 CTRL, R/W: bit0 enable, bit1 irq_en; other bits read 0.
  - 0xC DIV, R/W, bits[15:0]. Writes below 4 store 4. Bits [31:16] read 0.
- perr=1 (with pready) for: a write to DATA, or any write with pstb != 4'hF. An erroring write has no side effect.
- FSM states: IDLE, START, DATA, STOP. A 16-bit down-counter cnt and a 3-bit bit index bidx are used.
  - IDLE: if enable and rx_s==0, set cnt=DIV>>1 and go to START.
  - START: when cnt==0:
    - If rx_s==0: cnt=DIV-1, bidx=0, go to DATA.
    - Else (glitch): go to IDLE.
    - Otherwise cnt decrements.
  - DATA: when cnt==0:
    - Shift rx_s into the shift register, LSB first, and reload cnt=DIV-1.
    - After bidx==7, go to STOP; otherwise bidx increments.
  - STOP: when cnt==0:
    - If rx_s==1: push the byte. If the FIFO is full, drop the byte and set overrun.
    - If rx_s==0: set framing_err and discard the byte.
    - Go to IDLE in the same edge.
- enable=0 forces the FSM to IDLE immediately (frame aborted); the FIFO contents are retained.
- A DIV write mid-frame takes effect at the next counter reload.
- Simultaneous push and pop in one cycle: the pop happens first. When full, the push then succeeds, no overrun is set, and count is unchanged.
- Simultaneous clear-write and set of a sticky bit in the same cycle: the set wins.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits; count = wptr - rptr. Wrap-around is transparent.
- irq = irq_en & (not_empty | overrun | framing_err), registered, so it asserts 1 cycle after the cause.

Test Plan:
- Reset, then read 0x4 and 0xC -> STATUS=0x0, DIV=868. Read 0x0 -> 0x80000000, pready=1, perr=0.
- DIV=16, CTRL=0x3, send 0xA5 8N1 at 16 clk/bit -> STATUS.count=1. irq=1 within 2 cycles of the stop sample. Read DATA -> 0x000000A5, then irq=0.
- Send 17 bytes 0x00..0x10 without reading -> full=1, overrun=1. Reads return 0x00..0x0F and then 0x80000000. Write 0x4 with 0x4 -> overrun=0.
- Frame 0x3C with stop bit driven 0 -> framing_err=1, count stays 0. An 8-clock low glitch on rx at DIV=32 -> no byte, no error.
- Write DATA, then a write to CTRL with pstb=4'h1 -> perr=1 each time, CTRL unchanged. Write DIV=2 -> reads back 4.
- Assert rts=0 mid-frame (bidx=3), release, send 0x5A -> only 0x5A is received.
- Set CTRL.enable=0 mid-frame -> no byte pushed.
